// File: rtl/store_queue.sv
// store_queue: in-order store buffer. Stores allocate at the tail, collect their
// address (addr_*) and data (a_data or a CDB broadcast), and become eligible to drain
// once the ROB commits them. Committed heads drain to memory over o_valid/o_ready.
// A committed head that was invalidated is dropped in one cycle and never shown on o_*.
// flush discards every uncommitted entry. Committed entries always form a contiguous
// run starting at the head.
// Loads probe the queue combinationally over ld_valid/ld_addr and receive:
//   ld_hit   - forwarded data on ld_data,
//   ld_block - load must wait,
//   neither  - load may read memory.
// Ports: clk, nrst (synchronous, active-high); a_* allocate; addr_* address update;
// cdb_* data broadcast {tag,data}; commit_*; flush; ld_* lookup; o_* drain; count.
// Macro STORE_QUEUE_FORWARD_EN: when defined, ready matching stores forward their data.
// When undefined, any address match blocks the load.
module store_queue #(
  parameter int DEPTH_W  = 2,
  parameter int DATA_W   = 32,
  parameter int RSV_ID_W = 6,
  parameter int INSTR_W  = 6
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [RSV_ID_W-1:0]        a_rob_id,
  input  logic [INSTR_W-1:0]         a_opcode,
  input  logic [DATA_W-1:0]          a_data,
  input  logic [RSV_ID_W-1:0]        a_data_rob_id,
  input  logic                       a_data_filled,
  input  logic                       addr_valid,
  input  logic [RSV_ID_W-1:0]        addr_rob_id,
  input  logic [DATA_W-1:0]          addr,
  input  logic                       cdb_valid,
  input  logic [RSV_ID_W+DATA_W-1:0] cdb,
  input  logic                       commit_valid,
  input  logic                       commit_invalidate,
  input  logic [RSV_ID_W-1:0]        commit_id,
  input  logic                       flush,
  input  logic                       ld_valid,
  input  logic [DATA_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic                       ld_block,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [INSTR_W-1:0]         o_opcode,
  output logic [RSV_ID_W-1:0]        o_rsv_id,
  output logic [DATA_W-1:0]          o_address,
  output logic [DATA_W-1:0]          o_data,
  output logic [DEPTH_W:0]           count
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] DEPTH_CNT = (DEPTH_W+1)'(DEPTH);
  localparam logic [DEPTH_W:0] ONE = (DEPTH_W+1)'(1);

  // Pointers carry one extra bit so that full and empty remain distinguishable.
  logic [DEPTH_W:0]   head, tail;
  logic [DEPTH_W-1:0] head_idx, tail_idx;

  logic                ent_vld  [DEPTH];
  logic                ent_drdy [DEPTH];
  logic                ent_ardy [DEPTH];
  logic                ent_cmt  [DEPTH];
  logic                ent_inv  [DEPTH];
  logic [RSV_ID_W-1:0] ent_rob  [DEPTH];
  logic [RSV_ID_W-1:0] ent_drob [DEPTH];
  logic [INSTR_W-1:0]  ent_op   [DEPTH];
  logic [DATA_W-1:0]   ent_data [DEPTH];
  logic [DATA_W-1:0]   ent_addr [DEPTH];

  logic [RSV_ID_W-1:0] cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic                full, do_alloc, head_cmt, do_pop;
  logic [DEPTH_W:0]    cmt_cnt;

  assign cdb_tag  = cdb[DATA_W +: RSV_ID_W];
  assign cdb_data = cdb[DATA_W-1:0];
  assign head_idx = head[DEPTH_W-1:0];
  assign tail_idx = tail[DEPTH_W-1:0];

  assign count    = tail - head;
  assign full     = (count == DEPTH_CNT);
  // Derived only from registered occupancy, so a same-cycle drain cannot raise it.
  assign a_ready  = !full;
  assign do_alloc = a_valid && a_ready && !flush;

  assign head_cmt = ent_vld[head_idx] && ent_cmt[head_idx];
  assign o_valid  = head_cmt && !ent_inv[head_idx] && ent_ardy[head_idx] && ent_drdy[head_idx];
  // Invalidated committed heads retire without a memory handshake.
  assign do_pop   = (o_valid && o_ready) || (head_cmt && ent_inv[head_idx]);

  assign o_opcode  = o_valid ? ent_op[head_idx]   : '0;
  assign o_rsv_id  = o_valid ? ent_rob[head_idx]  : '0;
  assign o_address = o_valid ? ent_addr[head_idx] : '0;
  assign o_data    = o_valid ? ent_data[head_idx] : '0;

  // Length of the committed run starting at the head; the tail lands just past it on flush.
  always_comb begin
    logic               run;
    logic [DEPTH_W-1:0] idx;
    cmt_cnt = '0;
    run     = 1'b1;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + DEPTH_W'(k);
      if (run && ent_vld[idx] && ent_cmt[idx]) cmt_cnt = cmt_cnt + ONE;
      else run = 1'b0;
    end
  end

  // Load lookup. Valid entries sit contiguously from head to tail, so walking from the
  // head and letting later matches overwrite earlier ones leaves the youngest match.
  always_comb begin
    logic               any_open;
    logic               match;
    logic [DEPTH_W-1:0] idx;
`ifdef STORE_QUEUE_FORWARD_EN
    logic               match_drdy;
    logic [DATA_W-1:0]  match_data;
    match_drdy = 1'b0;
    match_data = '0;
`endif
    any_open = 1'b0;
    match    = 1'b0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + DEPTH_W'(k);
      if (ent_vld[idx] && !ent_inv[idx]) begin
        if (!ent_ardy[idx]) begin
          any_open = 1'b1;
        end else if (ent_addr[idx] == ld_addr) begin
          match = 1'b1;
`ifdef STORE_QUEUE_FORWARD_EN
          match_drdy = ent_drdy[idx];
          match_data = ent_data[idx];
`endif
        end
      end
    end
    ld_hit   = 1'b0;
    ld_block = 1'b0;
    ld_data  = '0;
    if (ld_valid) begin
`ifdef STORE_QUEUE_FORWARD_EN
      if (any_open) begin
        ld_block = 1'b1;
      end else if (match) begin
        // The all-ones address is never forwarded.
        if (match_drdy && (ld_addr != '1)) begin
          ld_hit  = 1'b1;
          ld_data = match_data;
        end else begin
          ld_block = 1'b1;
        end
      end
`else
      ld_block = any_open || match;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_vld[i]  <= 1'b0;
        ent_drdy[i] <= 1'b0;
        ent_ardy[i] <= 1'b0;
        ent_cmt[i]  <= 1'b0;
        ent_inv[i]  <= 1'b0;
        ent_rob[i]  <= '0;
        ent_drob[i] <= '0;
        ent_op[i]   <= '0;
        ent_data[i] <= '0;
        ent_addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_vld[i] && cdb_valid && !ent_drdy[i] && (ent_drob[i] == cdb_tag)) begin
          ent_data[i] <= cdb_data;
          ent_drdy[i] <= 1'b1;
        end
        if (ent_vld[i] && addr_valid && (ent_rob[i] == addr_rob_id)) begin
          ent_addr[i] <= addr;
          ent_ardy[i] <= 1'b1;
        end
        if (ent_vld[i] && commit_valid && (ent_rob[i] == commit_id)) begin
          ent_cmt[i] <= 1'b1;
          ent_inv[i] <= commit_invalidate;
        end
      end

      // The tail slot is empty whenever an allocation is accepted, so the loop above never
      // touches it.
      if (do_alloc) begin
        ent_vld[tail_idx]  <= 1'b1;
        ent_rob[tail_idx]  <= a_rob_id;
        ent_op[tail_idx]   <= a_opcode;
        ent_drob[tail_idx] <= a_data_rob_id;
        ent_ardy[tail_idx] <= 1'b0;
        ent_cmt[tail_idx]  <= 1'b0;
        ent_inv[tail_idx]  <= 1'b0;
        ent_addr[tail_idx] <= '0;
        if (!a_data_filled && cdb_valid && (cdb_tag == a_data_rob_id)) begin
          ent_data[tail_idx] <= cdb_data;
          ent_drdy[tail_idx] <= 1'b1;
        end else begin
          ent_data[tail_idx] <= a_data;
          ent_drdy[tail_idx] <= a_data_filled;
        end
      end

      if (do_pop) begin
        ent_vld[head_idx] <= 1'b0;
        head              <= head + ONE;
      end

      // Commit state is taken from before this edge, so a same-cycle commit of an
      // uncommitted entry is discarded along with that entry.
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!ent_cmt[i]) begin
            ent_vld[i] <= 1'b0;
            ent_cmt[i] <= 1'b0;
            ent_inv[i] <= 1'b0;
          end
        end
        tail <= head + cmt_cnt;
      end else if (do_alloc) begin
        tail <= tail + ONE;
      end
    end
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH_W, default 2, log2 of the entry count (queue depth = 2**DEPTH_W).
REQ-002 SHALL have parameter DATA_W, default 32, the data and address width.
REQ-003 SHALL have parameter RSV_ID_W, default 6, the ROB tag width.
REQ-004 SHALL have parameter INSTR_W, default 6, the opcode width.
REQ-005 SHALL have the following ports:
- clk  in  1  the single clock; one clock, reset is synchronous and active-high.
- nrst  in  1  synchronous, active-high reset.
- a_valid/a_ready  in/out  1/1  store allocate handshake.
- a_rob_id, a_opcode, a_data, a_data_rob_id, a_data_filled  in  RSV_ID_W/INSTR_W/DATA_W/RSV_ID_W/1  allocate payload.
- addr_valid, addr_rob_id, addr  in  1/RSV_ID_W/DATA_W  computed store address.
- cdb_valid, cdb  in  1/(RSV_ID_W+DATA_W)  common data bus, formatted {tag,data}.
- commit_valid, commit_invalidate, commit_id  in  1/1/RSV_ID_W  ROB commit.
- flush  in  1  discard all uncommitted entries.
- ld_valid, ld_addr  in  1/DATA_W  load lookup.
- ld_hit, ld_block, ld_data  out  1/1/DATA_W  lookup result (combinational).
- o_valid/o_ready  out/in  1/1  memory drain handshake.
- o_opcode, o_rsv_id, o_address, o_data  out  INSTR_W/RSV_ID_W/DATA_W/DATA_W  drain payload.
- count  out  DEPTH_W+1  number of occupied entries.

Function
REQ-006 SHALL be a circular FIFO with head and tail pointers of width DEPTH_W+1 that wrap modulo 2*depth; the queue is full when count==depth and empty when count==0.
REQ-007 SHALL drive a_ready = !full, computed from registered state; a drain in the same cycle SHALL NOT make a_ready high.
REQ-008 SHALL write the tail entry on a_valid&a_ready; data_ready=a_data_filled; an allocation whose a_data_rob_id matches a same-cycle CDB broadcast SHALL capture cdb data with data_ready=1.
REQ-009 SHALL capture cdb data into every valid entry with !data_ready and data_rob_id==cdb tag.
REQ-010 SHALL, on addr_valid, set addr and addr_ready in the valid entry with rob_id==addr_rob_id; no matching entry means no state change.
REQ-011 SHALL, on commit_valid, set committed=1 and invalidate=commit_invalidate in the matching entry.
REQ-012 SHALL assert o_valid when the head entry is valid&committed&addr_ready&data_ready&!invalidate; the head SHALL pop on o_valid&o_ready.
REQ-013 SHALL pop an invalidated committed head entry in one cycle with o_valid=0.
REQ-014 SHALL hold o_* payload at 0 whenever o_valid=0.
REQ-015 SHALL compute the lookup, when ld_valid=1, over valid non-invalidated entries:
- any entry with !addr_ready gives ld_block=1;
- otherwise the youngest entry (nearest tail) with addr==ld_addr decides:
  - data_ready and ld_addr!=all-ones gives ld_hit=1 with ld_data=entry data;
  - otherwise ld_block=1;
- no match gives ld_hit=ld_block=0.
REQ-016 SHALL keep ld_hit, ld_block and ld_data at 0 when ld_valid=0 or the queue is empty.
REQ-017 SHALL, on flush, clear every uncommitted entry and set tail=head+(committed count), since committed entries are contiguous from head; committed entries continue draining.
REQ-018 SHALL give flush priority over allocate, address, CDB and commit updates to uncommitted entries in the same cycle; a same-cycle pop SHALL still occur.
REQ-019 SHALL apply pointer wrap-around at depth-1→0 for indexing, with no loss of the full/empty distinction.

Reset
REQ-020 SHALL, when nrst=1 at a clk edge, clear all entries and pointers; count, o_valid, a_ready (on the following cycle, a_ready=1), ld_hit and ld_block take their reset values; reset SHALL override all same-cycle events.
REQ-021 SHALL return all outputs to their reset values on the next edge after a reset asserted mid-drain, without completing the drain handshake.

Configuration
REQ-022 SHALL, with macro STORE_QUEUE_FORWARD_EN defined, forward data per REQ-015.
REQ-023 SHALL, with STORE_QUEUE_FORWARD_EN undefined, tie ld_hit=0 and ld_data=0 and turn any address match into ld_block=1.

Verification
REQ-024 Fill test: 4 allocates with DEPTH_W=2 → a_ready=0 and count=4; then one pop → a_ready=1 on the next cycle.
REQ-025 Youngest forward: stores to 0x100 with data 0xA (older) and 0xB (younger), all ready; ld_addr=0x100 → ld_hit=1, ld_data=0xB.
REQ-026 Late data: store with a_data_filled=0 and tag 5; lookup → ld_block=1; cdb={5,0x77} → the next lookup gives ld_hit=1, ld_data=0x77.
REQ-027 Invalidate: head commit with commit_invalidate=1 → popped in 1 cycle, o_valid never 1, count decrements.
REQ-028 Flush: 2 committed plus 2 uncommitted entries, flush → count=2; both drain in order, then the queue is empty.
REQ-029 Without STORE_QUEUE_FORWARD_EN: repeat REQ-025 → ld_hit=0, ld_block=1.
